// File: rtl/alu_pkg.sv
// Shared types for the handshaked ALU: opcodes, FSM states and response flags.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StHold
  } alu_state_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic ovf;
    logic err;
  } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] step_acc;

  // Next-state: load on start, otherwise shift/accumulate while iterations remain.
  always_comb begin
    step_acc = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = CntW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_d    = step_acc;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntW'(1);
    end
  end

  // The final iteration's sum is presented directly so the caller can latch it on that edge.
  assign done_o    = (cnt_q == CntW'(1));
  assign product_o = step_acc;

  // Multiplier state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU: single-cycle ops land in HOLD one edge after accept, MUL iterates first.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [15:0]      ops_done
);

  localparam int unsigned ShW = $clog2(WIDTH);
  localparam int unsigned Msb = WIDTH - 1;

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  alu_flags_t       flags_q, flags_d;
  logic [15:0]      ops_done_q, ops_done_d;

  alu_op_e          op;
  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;
  logic [WIDTH:0]   add_ext, sub_ext;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  alu_flags_t       alu_flags;

  assign op        = alu_op_e'(req_op);
  assign shamt     = req_b[ShW-1:0];
  // HOLD can take a new request in the same cycle its response is consumed.
  assign req_ready = (state_q == StIdle) || ((state_q == StHold) && rsp_ready);
  assign accept    = req_valid && req_ready;
  assign mul_start = accept && (op == OP_MUL);

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (mul_start),
    .a_i      (req_a),
    .b_i      (req_b),
    .done_o   (mul_done),
    .product_o(mul_prod)
  );

  // Single-cycle datapath and flags, evaluated on the live request fields.
  always_comb begin
    add_ext   = {1'b0, req_a} + {1'b0, req_b};
    sub_ext   = {1'b0, req_a} - {1'b0, req_b};
    alu_res   = '0;
    alu_flags = '0;
    case (op)
      OP_ADD: begin
        alu_res         = add_ext[WIDTH-1:0];
        alu_flags.carry = add_ext[WIDTH];
        alu_flags.ovf   = (req_a[Msb] == req_b[Msb]) && (alu_res[Msb] != req_a[Msb]);
      end
      OP_SUB: begin
        alu_res         = sub_ext[WIDTH-1:0];
        alu_flags.carry = sub_ext[WIDTH];  // borrow: a < b unsigned
        alu_flags.ovf   = (req_a[Msb] != req_b[Msb]) && (alu_res[Msb] != req_a[Msb]);
      end
      OP_AND:  alu_res = req_a & req_b;
      OP_OR:   alu_res = req_a | req_b;
      OP_XOR:  alu_res = req_a ^ req_b;
      OP_SLL:  alu_res = req_a << shamt;
      OP_SRL:  alu_res = req_a >> shamt;
      OP_SRA:  alu_res = $signed(req_a) >>> shamt;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(req_a) < $signed(req_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (req_a < req_b)};
      OP_MUL:  alu_res = '0;  // produced by the iterative unit
      default: alu_flags.err = 1'b1;
    endcase
    alu_flags.zero = !alu_flags.err && (alu_res == '0);
  end

  // FSM next-state plus response register loading.
  always_comb begin
    state_d    = state_q;
    result_d   = result_q;
    tag_d      = tag_q;
    flags_d    = flags_q;
    ops_done_d = ops_done_q;
    if ((state_q == StHold) && rsp_ready) begin
      ops_done_d = ops_done_q + 16'd1;
    end
    case (state_q)
      StIdle, StHold: begin
        if ((state_q == StHold) && rsp_ready) begin
          state_d = StIdle;
        end
        if (accept) begin
          tag_d = req_tag;
          if (op == OP_MUL) begin
            state_d = StMul;
          end else begin
            state_d  = StHold;
            result_d = alu_res;
            flags_d  = alu_flags;
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d      = StHold;
          result_d     = mul_prod;
          flags_d      = '0;
          flags_d.zero = (mul_prod == '0);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and response registers; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      result_q   <= '0;
      tag_q      <= '0;
      flags_q    <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      result_q   <= result_d;
      tag_q      <= tag_d;
      flags_q    <= flags_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign rsp_valid  = (state_q == StHold);
  assign rsp_result = result_q;
  assign rsp_tag    = tag_q;
  assign rsp_zero   = flags_q.zero;
  assign rsp_carry  = flags_q.carry;
  assign rsp_ovf    = flags_q.ovf;
  assign rsp_err    = flags_q.err;
  assign ops_done   = ops_done_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: stimulus pushes expectations, monitor pops on handshake.
module tb_alu_pipe;

  localparam int unsigned W  = 8;
  localparam int unsigned TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_op;
  logic [W-1:0]  req_a, req_b;
  logic [TW-1:0] req_tag;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [W-1:0]  rsp_result;
  logic [TW-1:0] rsp_tag;
  logic          rsp_zero, rsp_carry, rsp_ovf, rsp_err;
  logic [15:0]   ops_done;

  alu_pipe #(
    .WIDTH(W),
    .TAG_W(TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_tag   (req_tag),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_result(rsp_result),
    .rsp_tag   (rsp_tag),
    .rsp_zero  (rsp_zero),
    .rsp_carry (rsp_carry),
    .rsp_ovf   (rsp_ovf),
    .rsp_err   (rsp_err),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  result;
    logic [TW-1:0] tag;
    logic          zero;
    logic          carry;
    logic          ovf;
    logic          err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests    = 0;
  int   fails    = 0;
  int   n_pushed = 0;
  int   cyc      = 0;
  int   rsp_cyc[$];
  int   waited;
  int   cnt;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_rsp(input logic [W-1:0] r, input logic [TW-1:0] t,
                         input logic z, input logic c, input logic o, input logic e);
    exp_t x;
    x.result = r;
    x.tag    = t;
    x.zero   = z;
    x.carry  = c;
    x.ovf    = o;
    x.err    = e;
    sb.push_back(x);
    n_pushed++;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t, output int w);
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = t;
    req_valid = 1'b1;
    w         = 0;
    @(negedge clk);
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) chk("accept_timeout", 32'(w), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every response handshake against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        rsp_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_rsp: got tag %0d result 0x%0h, expected no response",
                   rsp_tag, rsp_result);
        end else begin
          mon_e = sb.pop_front();
          chk("rsp_result", 32'(rsp_result), 32'(mon_e.result));
          chk("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
          chk("rsp_flags", {28'd0, rsp_zero, rsp_carry, rsp_ovf, rsp_err},
              {28'd0, mon_e.zero, mon_e.carry, mon_e.ovf, mon_e.err});
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_ops_done", 32'(ops_done), 32'd0);
    chk("reset_fields", {20'd0, rsp_result, rsp_tag},  32'd0);
    chk("reset_flags", {28'd0, rsp_zero, rsp_carry, rsp_ovf, rsp_err}, 32'd0);
    align();

    // ADD wrap to zero, then confirm the handshake counter.
    exp_rsp(8'h00, 4'd3, 1, 1, 0, 0); issue(4'd0, 8'hFF, 8'h01, 4'd3, waited);
    align();
    chk("ops_done_after_first", 32'(ops_done), 32'd1);

    // Back-to-back single-cycle ops.
    exp_rsp(8'h7F, 4'd4, 0, 0, 1, 0); issue(4'd1, 8'h80, 8'h01, 4'd4, waited);
    exp_rsp(8'h01, 4'd5, 0, 0, 0, 0); issue(4'd8, 8'h80, 8'h01, 4'd5, waited);
    exp_rsp(8'h00, 4'd6, 1, 0, 0, 0); issue(4'd9, 8'h80, 8'h01, 4'd6, waited);
    exp_rsp(8'h80, 4'd7, 0, 0, 1, 0); issue(4'd0, 8'h7F, 8'h01, 4'd7, waited);
    exp_rsp(8'hFF, 4'd8, 0, 1, 0, 0); issue(4'd1, 8'h01, 8'h02, 4'd8, waited);
    exp_rsp(8'h30, 4'd9, 0, 0, 0, 0); issue(4'd2, 8'hF0, 8'h3C, 4'd9, waited);
    exp_rsp(8'hFC, 4'd10, 0, 0, 0, 0); issue(4'd3, 8'hF0, 8'h0C, 4'd10, waited);
    exp_rsp(8'h04, 4'd11, 0, 0, 0, 0); issue(4'd5, 8'h81, 8'h0A, 4'd11, waited);
    exp_rsp(8'h10, 4'd12, 0, 0, 0, 0); issue(4'd6, 8'h81, 8'h0B, 4'd12, waited);
    exp_rsp(8'hC0, 4'd13, 0, 0, 0, 0); issue(4'd7, 8'h80, 8'h09, 4'd13, waited);
    exp_rsp(8'h00, 4'd14, 1, 0, 0, 0); issue(4'd7, 8'h40, 8'h0F, 4'd14, waited);

    // MUL 13*11: request side blocked for WIDTH cycles, response on the next.
    exp_rsp(8'h8F, 4'd1, 0, 0, 0, 0); issue(4'd10, 8'd13, 8'd11, 4'd1, waited);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (!req_ready && !rsp_valid) cnt++;
    end
    chk("mul_busy_cycles", 32'(cnt), 32'd8);
    @(negedge clk);
    chk("mul_rsp_valid_latency", 32'(rsp_valid), 32'd1);
    align();
    exp_rsp(8'h00, 4'd2, 1, 0, 0, 0); issue(4'd10, 8'h10, 8'h10, 4'd2, waited);
    exp_rsp(8'h01, 4'd3, 0, 0, 0, 0); issue(4'd10, 8'hFF, 8'hFF, 4'd3, waited);
    repeat (12) align();

    // Illegal opcode under back-pressure, then release with a new request waiting.
    rsp_ready = 1'b0;
    exp_rsp(8'h00, 4'd7, 0, 0, 0, 1); issue(4'd12, 8'h55, 8'hAA, 4'd7, waited);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rsp_valid && !req_ready && rsp_result == 8'h00 && rsp_tag == 4'd7 && rsp_err
          && !rsp_zero) cnt++;
    end
    chk("hold_stable_cycles", 32'(cnt), 32'd5);
    align();
    rsp_ready = 1'b1;
    exp_rsp(8'h05, 4'd8, 0, 0, 0, 0); issue(4'd0, 8'h02, 8'h03, 4'd8, waited);
    chk("release_accept_wait", 32'(waited), 32'd0);
    chk("release_new_tag", {27'd0, rsp_valid, rsp_tag}, {27'd0, 1'b1, 4'd8});

    // Four XORs back to back: responses on consecutive cycles.
    exp_rsp(8'h5A, 4'd9, 0, 0, 0, 0);  issue(4'd4, 8'hA5, 8'hFF, 4'd9, waited);
    exp_rsp(8'h00, 4'd10, 1, 0, 0, 0); issue(4'd4, 8'h0F, 8'h0F, 4'd10, waited);
    exp_rsp(8'h26, 4'd11, 0, 0, 0, 0); issue(4'd4, 8'h12, 8'h34, 4'd11, waited);
    exp_rsp(8'h81, 4'd12, 0, 0, 0, 0); issue(4'd4, 8'h80, 8'h01, 4'd12, waited);
    repeat (3) align();
    if (rsp_cyc.size() >= 4) begin
      chk("xor_consecutive",
          32'(rsp_cyc[rsp_cyc.size()-1] - rsp_cyc[rsp_cyc.size()-4]), 32'd3);
    end else begin
      chk("xor_rsp_count", 32'(rsp_cyc.size()), 32'd4);
    end
    chk("ops_done_total", 32'(ops_done), 32'(n_pushed));

    // Reset mid-MUL: the op is dropped and nothing comes out afterwards.
    issue(4'd10, 8'd7, 8'd9, 4'd13, waited);
    align();
    align();
    rst = 1'b1;
    align();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mul_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mul_ops_done", 32'(ops_done), 32'd0);
    chk("rst_mul_req_ready", 32'(req_ready), 32'd1);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    chk("rst_no_stale_rsp", 32'(cnt), 32'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
